// File: rtl/nonce_reporter.sv
// Serialises nonce decoder results into tag/nonce byte frames on a valid/ready byte stream.
// Optional trailing XOR checksum byte when NONCE_REPORTER_CHECKSUM_EN is defined.
module nonce_reporter #(
  parameter logic [7:0]  SUCCESS_TAG = 8'hA5,
  parameter logic [7:0]  FAIL_TAG    = 8'h5A,
  parameter int unsigned DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              success_i,
  input  logic [31:0]       nonce_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [7:0]        data_o,
  output logic              busy_o,
  output logic [DROP_W-1:0] dropped_o
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {IDLE, TAG, NONCE, CSUM} state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               frm_succ_q, frm_succ_n;
  logic [NONCE_W-1:0] frm_nonce_q, frm_nonce_n;
  logic               pend_full_q, pend_full_n;
  logic               pend_succ_q, pend_succ_n;
  logic [NONCE_W-1:0] pend_nonce_q, pend_nonce_n;
  logic [DROP_W-1:0]  drop_n;
  logic               valid_n, busy_n;
  logic [7:0]         data_n;
  logic               xfer_c, eof_c, slot_free_c;

  // Next-state, frame/pending bookkeeping and registered output decode
  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    frm_succ_n   = frm_succ_q;
    frm_nonce_n  = frm_nonce_q;
    pend_full_n  = pend_full_q;
    pend_succ_n  = pend_succ_q;
    pend_nonce_n = pend_nonce_q;
    drop_n       = dropped_o;
    valid_n      = 1'b0;
    data_n       = data_o;
    busy_n       = 1'b0;
    eof_c        = 1'b0;
    xfer_c       = valid_o & ready_i;

    case (state_q)
      TAG: begin
        if (xfer_c) begin
          if (frm_succ_q) begin
            state_n = NONCE;
            idx_n   = IDX_W'(3);
          end else begin
`ifdef NONCE_REPORTER_CHECKSUM_EN
            state_n = CSUM;
`else
            eof_c   = 1'b1;
`endif
          end
        end
      end
      NONCE: begin
        if (xfer_c) begin
          if (idx_q == IDX_W'(0)) begin
`ifdef NONCE_REPORTER_CHECKSUM_EN
            state_n = CSUM;
`else
            eof_c   = 1'b1;
`endif
          end else begin
            idx_n = idx_q - IDX_W'(1);
          end
        end
      end
      CSUM: begin
        if (xfer_c) eof_c = 1'b1;
      end
      default: ;
    endcase

    // Frame slot frees up in IDLE or on the last-byte transfer; pending has priority over a new result
    slot_free_c = (state_q == IDLE) | eof_c;
    if (slot_free_c) begin
      if (pend_full_q) begin
        state_n     = TAG;
        frm_succ_n  = pend_succ_q;
        frm_nonce_n = pend_nonce_q;
        pend_full_n = valid_i;
        if (valid_i) begin
          pend_succ_n  = success_i;
          pend_nonce_n = success_i ? nonce_i : '0;
        end
      end else if (valid_i) begin
        state_n     = TAG;
        frm_succ_n  = success_i;
        frm_nonce_n = success_i ? nonce_i : '0;
      end else begin
        state_n = IDLE;
      end
    end else if (valid_i) begin
      if (!pend_full_q) begin
        pend_full_n  = 1'b1;
        pend_succ_n  = success_i;
        pend_nonce_n = success_i ? nonce_i : '0;
      end else if (dropped_o != {DROP_W{1'b1}}) begin
        drop_n = dropped_o + DROP_W'(1);
      end
    end

    valid_n = (state_n != IDLE);
    busy_n  = (state_n != IDLE) | pend_full_n;
    case (state_n)
      TAG:     data_n = frm_succ_n ? SUCCESS_TAG : FAIL_TAG;
      NONCE:   data_n = frm_nonce_n[{idx_n, 3'b000} +: 8];
`ifdef NONCE_REPORTER_CHECKSUM_EN
      // Fail frames carry a zero nonce, so the nonce bytes cancel out of the XOR
      CSUM:    data_n = (frm_succ_n ? SUCCESS_TAG : FAIL_TAG) ^ frm_nonce_n[31:24]
                        ^ frm_nonce_n[23:16] ^ frm_nonce_n[15:8] ^ frm_nonce_n[7:0];
`endif
      default: data_n = data_o;
    endcase
  end

  // State, frame, pending and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frm_succ_q   <= 1'b0;
      frm_nonce_q  <= '0;
      pend_full_q  <= 1'b0;
      pend_succ_q  <= 1'b0;
      pend_nonce_q <= '0;
      dropped_o    <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      frm_succ_q   <= frm_succ_n;
      frm_nonce_q  <= frm_nonce_n;
      pend_full_q  <= pend_full_n;
      pend_succ_q  <= pend_succ_n;
      pend_nonce_q <= pend_nonce_n;
      dropped_o    <= drop_n;
      valid_o      <= valid_n;
      data_o       <= data_n;
      busy_o       <= busy_n;
    end
  end

endmodule

// File: tb/tb_nonce_reporter.sv
// Scoreboard bench for nonce_reporter: expected frame bytes are queued at stimulus time
// and popped on each byte transfer.
module tb_nonce_reporter;

`ifdef NONCE_REPORTER_CHECKSUM_EN
  localparam int FLEN_S = 6;
  localparam int FLEN_F = 2;
`else
  localparam int FLEN_S = 5;
  localparam int FLEN_F = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, success_i, ready_i;
  logic [31:0] nonce_i;
  logic        valid_o, busy_o;
  logic [7:0]  data_o;
  logic [7:0]  dropped_o;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       stall;
  logic [7:0] held;
  int         run, last_run;

  nonce_reporter dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .success_i(success_i), .nonce_i(nonce_i),
    .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o), .dropped_o(dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transfer monitor: pops the scoreboard, checks hold-under-backpressure, measures valid_o runs
  always @(negedge clk) begin
    if (rst) begin
      if (stall) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_data", 32'(data_o), 32'(held));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
        else chk("byte", 32'(data_o), 32'(exp_q.pop_front()));
      end
      stall = valid_o && !ready_i;
      held  = data_o;
      if (valid_o) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end else begin
      stall = 1'b0;
      run   = 0;
    end
  end

  // One-cycle result pulse; optionally queue the frame it should produce
  task automatic send(input logic s, input logic [31:0] n, input bit push);
    logic [7:0] cs;
    valid_i   = 1'b1;
    success_i = s;
    nonce_i   = n;
    if (push) begin
      if (s) begin
        exp_q.push_back(8'hA5);
        cs = 8'hA5;
        for (int b = 3; b >= 0; b--) begin
          exp_q.push_back(n[8*b +: 8]);
          cs = cs ^ n[8*b +: 8];
        end
      end else begin
        exp_q.push_back(8'h5A);
        cs = 8'h5A;
      end
`ifdef NONCE_REPORTER_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
    end
    @(posedge clk) #1;
    valid_i = 1'b0;
    nonce_i = $urandom;
  endtask

  task automatic wait_idle(input bit rand_ready);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk) #1;
      if (!busy_o && !valid_o && exp_q.size() == 0) done = 1'b1;
    end
    ready_i = 1'b1;
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; success_i = 1'b0; nonce_i = '0; ready_i = 1'b1;
    stall = 1'b0; held = '0; run = 0; last_run = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dropped", 32'(dropped_o), 32'd0);
    rst = 1'b1;
    @(posedge clk) #1;

    // Success frame, first byte one cycle after the strobe
    send(1'b1, 32'h1234ABCD, 1'b1);
    chk("lat_valid", 32'(valid_o), 32'd1);
    chk("lat_data", 32'(data_o), 32'hA5);
    chk("lat_busy", 32'(busy_o), 32'd1);
    wait_idle(1'b0);
    chk("succ_run", 32'(last_run), 32'(FLEN_S));
    chk("idle_valid", 32'(valid_o), 32'd0);

    // Fail frame: nonce must not appear
    send(1'b0, 32'hDEADBEEF, 1'b1);
    wait_idle(1'b0);
    chk("fail_run", 32'(last_run), 32'(FLEN_F));

    // Backpressure on byte 2 for 3 cycles
    send(1'b1, 32'h1234ABCD, 1'b1);
    for (int i = 0; i < 20 && !(valid_o && data_o == 8'h34); i++) @(posedge clk) #1;
    chk("bp_reach", 32'(data_o), 32'h34);
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held", 32'(data_o), 32'h34);
    ready_i = 1'b1;
    wait_idle(1'b0);
    chk("bp_run", 32'(last_run), 32'(FLEN_S + 3));

    // Overflow: second result pends, third dropped, frames back-to-back
    send(1'b1, 32'h01020304, 1'b1);
    send(1'b1, 32'hA0B0C0D0, 1'b1);
    send(1'b1, 32'hFFFFFFFF, 1'b0);
    chk("ovf_dropped", 32'(dropped_o), 32'd1);
    wait_idle(1'b0);
    chk("ovf_run", 32'(last_run), 32'(2 * FLEN_S));

    // New result on the last-byte transfer of a frame while pending is full: no drop
    send(1'b1, 32'h11223344, 1'b1);
    send(1'b0, 32'h55667788, 1'b1);
    repeat (FLEN_S - 2) @(posedge clk);
    #1;
    send(1'b1, 32'h99AABBCC, 1'b1);
    wait_idle(1'b0);
    chk("edge_run", 32'(last_run), 32'(FLEN_S + FLEN_F + FLEN_S));
    chk("edge_dropped", 32'(dropped_o), 32'd1);

    // Random results with random ready
    for (int k = 0; k < 4; k++) begin
      send(1'($urandom_range(0, 1)), $urandom, 1'b1);
      wait_idle(1'b1);
    end

    // Saturation: stalled link, 300 extra results all dropped
    ready_i = 1'b0;
    send(1'b1, 32'hCAFEF00D, 1'b0);
    send(1'b1, 32'h0BADC0DE, 1'b0);
    for (int k = 0; k < 300; k++) send(1'b0, 32'h0, 1'b0);
    chk("sat_dropped", 32'(dropped_o), 32'hFF);
    chk("sat_valid", 32'(valid_o), 32'd1);

    // Asynchronous reset mid-frame
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_dropped", 32'(dropped_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    ready_i = 1'b1;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;

    send(1'b1, 32'h87654321, 1'b1);
    wait_idle(1'b0);
    chk("post_rst_run", 32'(last_run), 32'(FLEN_S));
    chk("post_rst_dropped", 32'(dropped_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
